muldiv_ctrl: RTL

Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage. Accepts a mult/multu/div/divu request from the decoded instruction (ALUS/ALUU oper with FUNC_MUL/FUNC_DIV), runs an iterative shift-add multiply or restoring divide, stalls the pipeline while busy, then commits HI/LO. Also services mthi/mtlo writes and cancels in-flight work on exception flush.

---
 rtl/muldiv_ctrl_if.sv | 29 ++
 rtl/muldiv_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if -- request/response bundle between the EX stage and the
// multiply/divide sequencer.
//   master : EX-stage side (drives request, operands, mthi/mtlo strobes)
//   slave  : muldiv_ctrl side (drives stall, busy and the HI/LO registers)
interface muldiv_ctrl_if;
    logic        flush;
    logic        req;
    logic        op_div;
    logic        op_sign;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output flush, req, op_div, op_sign, src_a, src_b, wr_hi, wr_lo, wr_data,
        input  stall, busy, hi, lo
    );

    modport slave (
        input  flush, req, op_div, op_sign, src_a, src_b, wr_hi, wr_lo, wr_data,
        output stall, busy, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- multi-cycle multiply/divide sequencer and HI/LO owner.
// Runs mult/multu (iterative shift-add) and div/divu (restoring), stalls the
// pipeline while working, commits HI/LO from the DONE state, services
// mthi/mtlo and drops in-flight work on flush.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : muldiv_ctrl_if.slave (flush, req, op_div, op_sign, src_a, src_b,
//            wr_hi, wr_lo, wr_data in; stall, busy, hi, lo out)
// Build option: MULDIV_FAST_MUL_EN -- single-cycle combinational multiply,
// multiply requests go straight from IDLE to DONE.
module muldiv_ctrl (
    input  logic          clk,
    input  logic          resetn,
    muldiv_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [63:0] acc_d;
    logic [31:0] opnd_q;     // mul: |multiplicand|; div: |divisor|
    logic        neg_q;      // product / quotient must be negated
    logic        rneg_q;     // remainder takes the dividend's sign
    logic        div_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Operand sign and magnitude; unsigned ops treat both as non-negative.
    logic        sa, sb;
    logic [31:0] abs_a, abs_b;
    assign sa    = bus.op_sign & bus.src_a[31];
    assign sb    = bus.op_sign & bus.src_b[31];
    assign abs_a = sa ? (32'd0 - bus.src_a) : bus.src_a;
    assign abs_b = sb ? (32'd0 - bus.src_b) : bus.src_b;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic        [63:0] fast_prod;
    assign sprod     = $signed(bus.src_a) * $signed(bus.src_b);
    assign uprod     = {32'd0, bus.src_a} * {32'd0, bus.src_b};
    assign fast_prod = bus.op_sign ? sprod : uprod;
`endif

    // One iteration of either algorithm.
    logic [32:0] mul_sum;
    logic [32:0] div_rem;
    logic [32:0] div_diff;
    logic        div_ge;
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    assign div_rem  = acc_q[63:31];   // remainder shifted left, 33 bits so no bit is lost
    assign div_diff = div_rem - {1'b0, opnd_q};
    assign div_ge   = (div_rem >= {1'b0, opnd_q});

    always_comb begin
        acc_d = acc_q;
        case (state_q)
            S_MUL:   acc_d = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
            // Divisor 0 always "fits": quotient fills with ones, dividend
            // shifts out unchanged into the remainder.
            S_DIV:   acc_d = div_ge ? {div_diff[31:0], acc_q[30:0], 1'b1}
                                    : {acc_q[62:0], 1'b0};
            default: acc_d = acc_q;
        endcase
    end

    // Sign correction applied when committing from DONE.
    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic [31:0] res_hi, res_lo;
    assign prod   = neg_q  ? (64'd0 - acc_q)        : acc_q;
    assign quo    = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    assign rem    = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    assign res_hi = div_q ? rem : prod[63:32];
    assign res_lo = div_q ? quo : prod[31:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else if (bus.flush) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.wr_hi) hi_q <= bus.wr_data;
                    if (bus.wr_lo) lo_q <= bus.wr_data;
                    if (bus.req) begin
                        cnt_q  <= 5'd0;
                        neg_q  <= sa ^ sb;
                        rneg_q <= sa;
                        div_q  <= bus.op_div;
                        if (bus.op_div) begin
                            acc_q   <= {32'd0, abs_a};
                            opnd_q  <= abs_b;
                            state_q <= S_DIV;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            // Product is already signed-correct.
                            acc_q   <= fast_prod;
                            neg_q   <= 1'b0;
                            state_q <= S_DONE;
`else
                            acc_q   <= {32'd0, abs_b};
                            opnd_q  <= abs_a;
                            state_q <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_DONE;
                end
                S_DONE: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // DONE releases the stall so the instruction can leave EX.
    assign bus.stall = resetn & ~bus.flush &
                       (((state_q == S_IDLE) & bus.req) | (state_q == S_MUL) | (state_q == S_DIV));
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
